wave_lookup_pipe: RTL and testbench
===================================

// Module: wave_lookup_pipe
// PURPOSE
//  Pipelined, parametrised phase-to-amplitude converter: next generation of the combinational sine lookup.
//  Maps a PHASE_W phase word to an OUT_W unsigned offset-binary sample for the DAC path.
//  Modes: sine (quarter-wave ROM), triangle, sawtooth, square.
//  Sits between the phase accumulator (upstream valid/ready) and the DAC driver (downstream valid/ready).
// PARAMETERS
//  PHASE_W  16  phase input width; one full cycle = 2^PHASE_W.
//  OUT_W    12  sample width; midscale MID = 2^(OUT_W-1), amplitude A = MID-1.
//  LUT_AW    8  quarter-wave index bits; ROM holds 2^LUT_AW+1 entries. Requires PHASE_W >= LUT_AW+2.
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        phase/mode valid
//  in_ready   out  1        block accepts phase/mode this cycle
//  phase      in   PHASE_W  phase word
//  mode       in   2        0 sine, 1 triangle, 2 sawtooth, 3 square
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  result     out  OUT_W    unsigned offset-binary sample
// BEHAVIOUR
//  - Reset: all stage valids 0, out_valid=0, result=MID, in_ready=1. Reset mid-stream discards in-flight samples; none emerge after reset.
//  - Pipeline: S1 quadrant fold/address + mode decode; S2 registered ROM read; S3 sign/mode mux into result reg. Latency 3 (4 with INTERP_EN).
//  - Global advance en = !out_valid | out_ready. in_ready = en. Transfer on in_valid & in_ready. When en=0 every stage holds; no drop, no duplicate.
//  - Bubbles propagate as valid=0. mode travels with its phase; per-sample mode changes are legal.
//  - Sine: q = phase[PW-1:PW-2], i = phase[PW-3 -: LUT_AW]. ROM T[k] = round(A*sin(k*pi/2^(LUT_AW+1))), k = 0..2^LUT_AW.
//    Address: q even -> i; q odd -> 2^LUT_AW - i. mag = T[addr]. q<2 -> MID+mag; q>=2 -> MID-mag. Range [1, 2^OUT_W-1].
//  - Triangle: s = phase[PW-2 -: OUT_W]; phase MSB 0 -> s, MSB 1 -> ~s.
//  - Sawtooth: phase[PW-1 -: OUT_W].
//  - Square: phase MSB 0 -> 2^OUT_W-1; MSB 1 -> 0.
//  - If PHASE_W < OUT_W+1: triangle/saw use zero-padded LSBs.
//  - Arithmetic unsigned; all sine sums are provably in range, no saturation logic.
// CONFIGURATION
//  INTERP_EN defined: sine linear interpolation.
//    FW = PHASE_W-2-LUT_AW; f = low FW phase bits; neighbour n = addr+1 (q even) or addr-1 (q odd).
//    mag = T[addr] + ((T[n]-T[addr])*f >>> FW), signed difference. ROM is dual-read.
//    Adds one multiply stage: latency 4, all modes.
//  INTERP_EN undefined: nearest-lower lookup, latency 3, single-read ROM, no multiplier.
// STRUCTURE
//  - Package wave_pkg: mode enum (WAVE_SINE, WAVE_TRI, WAVE_SAW, WAVE_SQR) and midscale/amplitude constant functions.
//  - Sub-module sine_quarter_rom (params LUT_AW, OUT_W): registered synchronous read with enable.
//    Contents generated at elaboration from the T[k] formula; second read port present only under INTERP_EN.
// TESTING
//  1. rst=1 for 2 cycles -> out_valid=0, result=2048, in_ready=1; holds until first accepted input.
//  2. Sine, out_ready=1, phases 0x0000,0x4000,0x8000,0xC000 back-to-back -> 2048,4095,2048,1 on consecutive cycles starting 3 cycles after first accept.
//  3. Mode sweep -> saw 0x8000=2048; square 0x7FFF=4095, 0x8000=0; triangle 0x0000=0, 0x7FFF=4095, 0xFFFF=0.
//  4. 3 samples in flight, out_ready=0 for 5 cycles -> result/out_valid stable, in_ready=0; release -> drain in order, no loss or duplication.
//  5. rst pulsed with 2 samples in flight -> out_valid=0 next cycle; only post-reset inputs ever appear.
//  6. INTERP_EN, phase 0x0020 sine -> 2054 after 4 cycles (T[1]=13, f=32); without INTERP_EN -> 2048 after 3 cycles.
//  Random: scoreboard against a real-valued model, |err| <= 1 LSB (sine); exact match for other modes.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform lookup pipeline.
// Mode encoding plus midscale and amplitude helpers for offset-binary samples.
package wave_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE = 2'd0,
    WAVE_TRI  = 2'd1,
    WAVE_SAW  = 2'd2,
    WAVE_SQR  = 2'd3
  } wave_mode_e;

  function automatic int unsigned wave_mid(input int unsigned out_w);
    return 32'd1 << (out_w - 1);
  endfunction

  function automatic int unsigned wave_amp(input int unsigned out_w);
    return wave_mid(out_w) - 1;
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude ROM, T[k] = round(A*sin(k*pi/2^(LUT_AW+1))), k = 0..2^LUT_AW.
// Registered synchronous read with enable; second read port exists only when INTERP_EN is defined.
module sine_quarter_rom
  import wave_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 12
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [LUT_AW:0]   addr_a_i,
  output logic [OUT_W-1:0]  data_a_o
`ifdef INTERP_EN
  ,
  input  logic [LUT_AW:0]   addr_b_i,
  output logic [OUT_W-1:0]  data_b_o
`endif
);

  localparam int DEPTH = (1 << LUT_AW) + 1;

  function automatic logic [OUT_W-1:0] rom_entry(input int k);
    real ang;
    real v;
    ang = 3.14159265358979 * real'(k) / real'(2 ** (LUT_AW + 1));
    v   = real'(wave_amp(OUT_W)) * $sin(ang);
    return OUT_W'($rtoi(v + 0.5));
  endfunction

  logic [OUT_W-1:0] rom_w [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [OUT_W-1:0] ENTRY = rom_entry(k);
    assign rom_w[k] = ENTRY;
  end

  logic [OUT_W-1:0] data_a_q;

  always_ff @(posedge clk) begin
    if (en_i) data_a_q <= rom_w[addr_a_i];
  end

  assign data_a_o = data_a_q;

`ifdef INTERP_EN
  logic [OUT_W-1:0] data_b_q;

  always_ff @(posedge clk) begin
    if (en_i) data_b_q <= rom_w[addr_b_i];
  end

  assign data_b_o = data_b_q;
`endif

endmodule

// File: rtl/wave_lookup_pipe.sv
// Pipelined phase-to-amplitude converter: sine (quarter-wave ROM), triangle, sawtooth, square.
// INTERP_EN adds linear sine interpolation and one extra stage (latency 4 instead of 3).
module wave_lookup_pipe
  import wave_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 12,
  parameter int LUT_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PHASE_W-1:0] phase,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   result
);

  localparam logic [OUT_W-1:0] MID   = OUT_W'(wave_mid(OUT_W));
  localparam logic [LUT_AW:0]  QTR   = {1'b1, {LUT_AW{1'b0}}};
  localparam int               EXT_W = PHASE_W + OUT_W;

  logic en;

  // Stage 1 combinational decode
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  idx;
  logic [LUT_AW:0]    addr_d;
  logic [EXT_W-1:0]   ph_ext;
  logic [OUT_W-1:0]   tri_s;
  logic [OUT_W-1:0]   lin_d;

  logic               v1_q, neg1_q;
  wave_mode_e         mode1_q;
  logic [LUT_AW:0]    addr1_q;
  logic [OUT_W-1:0]   lin1_q;

  logic               v2_q, neg2_q;
  wave_mode_e         mode2_q;
  logic [OUT_W-1:0]   lin2_q;
  logic [OUT_W-1:0]   rom_a;

  logic               tail_v, tail_neg;
  wave_mode_e         tail_mode;
  logic [OUT_W-1:0]   tail_lin, tail_mag;

  logic               out_valid_q;
  logic [OUT_W-1:0]   result_q, result_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    quad   = phase[PHASE_W-1 -: 2];
    idx    = phase[PHASE_W-3 -: LUT_AW];
    addr_d = quad[0] ? (QTR - {1'b0, idx}) : {1'b0, idx};
    // Appending zeros covers narrow phase words for the triangle/saw slices.
    ph_ext = {phase, {OUT_W{1'b0}}};
    tri_s  = ph_ext[EXT_W-2 -: OUT_W];
    case (wave_mode_e'(mode))
      WAVE_TRI: lin_d = phase[PHASE_W-1] ? ~tri_s : tri_s;
      WAVE_SAW: lin_d = ph_ext[EXT_W-1 -: OUT_W];
      WAVE_SQR: lin_d = phase[PHASE_W-1] ? '0 : '1;
      default:  lin_d = '0;
    endcase
  end

`ifdef INTERP_EN
  localparam int FW  = PHASE_W - 2 - LUT_AW;
  localparam int FWE = (FW > 0) ? FW : 1;

  logic [LUT_AW:0]             addrn_d, addrn1_q;
  logic [FWE-1:0]              f_d, f1_q, f2_q;
  logic [OUT_W-1:0]            rom_b;
  logic signed [OUT_W:0]       diff;
  logic signed [OUT_W+FWE+1:0] prod, prod_sh;
  logic [OUT_W-1:0]            mag3_d;
  logic                        v3_q, neg3_q;
  wave_mode_e                  mode3_q;
  logic [OUT_W-1:0]            lin3_q, mag3_q;

  always_comb begin
    addrn_d = quad[0] ? (addr_d - 1'b1) : (addr_d + 1'b1);
    f_d     = (FW > 0) ? phase[FWE-1:0] : '0;
    diff    = $signed({1'b0, rom_b}) - $signed({1'b0, rom_a});
    prod    = diff * $signed({1'b0, f2_q});
    prod_sh = prod >>> FW;
    mag3_d  = rom_a + prod_sh[OUT_W-1:0];
  end

  sine_quarter_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_rom (
    .clk      (clk),
    .en_i     (en),
    .addr_a_i (addr1_q),
    .data_a_o (rom_a),
    .addr_b_i (addrn1_q),
    .data_b_o (rom_b)
  );

  assign tail_v    = v3_q;
  assign tail_neg  = neg3_q;
  assign tail_mode = mode3_q;
  assign tail_lin  = lin3_q;
  assign tail_mag  = mag3_q;
`else
  sine_quarter_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_rom (
    .clk      (clk),
    .en_i     (en),
    .addr_a_i (addr1_q),
    .data_a_o (rom_a)
  );

  assign tail_v    = v2_q;
  assign tail_neg  = neg2_q;
  assign tail_mode = mode2_q;
  assign tail_lin  = lin2_q;
  assign tail_mag  = rom_a;
`endif

  always_comb begin
    result_d = tail_lin;
    if (tail_mode == WAVE_SINE) result_d = tail_neg ? (MID - tail_mag) : (MID + tail_mag);
  end

  // One shared enable: every stage advances together or holds together.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      mode1_q     <= WAVE_SINE;
      mode2_q     <= WAVE_SINE;
      addr1_q     <= '0;
      lin1_q      <= '0;
      lin2_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= MID;
`ifdef INTERP_EN
      addrn1_q    <= '0;
      f1_q        <= '0;
      f2_q        <= '0;
      v3_q        <= 1'b0;
      neg3_q      <= 1'b0;
      mode3_q     <= WAVE_SINE;
      lin3_q      <= '0;
      mag3_q      <= '0;
`endif
    end else if (en) begin
      v1_q        <= in_valid;
      neg1_q      <= quad[1];
      mode1_q     <= wave_mode_e'(mode);
      addr1_q     <= addr_d;
      lin1_q      <= lin_d;
      v2_q        <= v1_q;
      neg2_q      <= neg1_q;
      mode2_q     <= mode1_q;
      lin2_q      <= lin1_q;
`ifdef INTERP_EN
      addrn1_q    <= addrn_d;
      f1_q        <= f_d;
      f2_q        <= f1_q;
      v3_q        <= v2_q;
      neg3_q      <= neg2_q;
      mode3_q     <= mode2_q;
      lin3_q      <= lin2_q;
      mag3_q      <= mag3_d;
`endif
      out_valid_q <= tail_v;
      if (tail_v) result_q <= result_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_wave_lookup_pipe.sv
// Self-checking bench for wave_lookup_pipe: directed vector table, latency/stall/reset
// sequences, and a randomized scoreboard run. Honours INTERP_EN for latency and sine values.
module tb_wave_lookup_pipe;

  localparam int PW = 16;
  localparam int OW = 12;
  localparam int AW = 8;
`ifdef INTERP_EN
  localparam int LAT        = 4;
  localparam int INTERP_EXP = 2054;
`else
  localparam int LAT        = 3;
  localparam int INTERP_EXP = 2048;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] phase;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] result;

  int passed = 0;
  int total  = 0;
  int cur_exp;
  bit sb_on = 1'b0;
  int expq [$];

  typedef struct {
    logic [15:0] ph;
    logic [1:0]  md;
    int          exp;
  } vec_t;

  vec_t        vecs [20];
  logic [15:0] ph4 [4];
  int          ex4 [4];

  always #5 clk = ~clk;

  wave_lookup_pipe #(
    .PHASE_W (PW),
    .OUT_W   (OW),
    .LUT_AW  (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .phase     (phase),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int tval(input int k);
    return int'($floor(2047.0 * $sin(3.14159265358979 * real'(k) / 512.0) + 0.5));
  endfunction

  function automatic int model(input logic [15:0] p, input logic [1:0] m);
    int q, i, a, mag;
    logic [11:0] s;
    logic [11:0] sn;
`ifdef INTERP_EN
    int n, d, f, pr;
`endif
    case (m)
      2'd0: begin
        q   = int'(p[15:14]);
        i   = int'(p[13:6]);
        a   = (q % 2 == 1) ? 256 - i : i;
        mag = tval(a);
`ifdef INTERP_EN
        f   = int'(p[5:0]);
        n   = (q % 2 == 0) ? a + 1 : a - 1;
        d   = tval(n) - mag;
        pr  = d * f;
        mag = mag + ((pr >= 0) ? pr / 64 : -((-pr + 63) / 64));
`endif
        return (q < 2) ? 2048 + mag : 2048 - mag;
      end
      2'd1: begin
        s  = p[14:3];
        sn = ~s;
        return p[15] ? int'(sn) : int'(s);
      end
      2'd2: return int'(p[15:4]);
      default: return p[15] ? 0 : 4095;
    endcase
  endfunction

  // Scoreboard: outputs are checked at the negedge before the transferring posedge.
  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          total++;
          $display("FAIL sb_unexpected: got result %0d with no sample outstanding", result);
        end else begin
          check("sb_result", int'(result), expq.pop_front());
        end
      end
      if (in_valid && in_ready) expq.push_back(cur_exp);
    end
  end

  task automatic send(input logic [15:0] p, input logic [1:0] m, input int e);
    phase    = p;
    mode     = m;
    cur_exp  = e;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && expq.size() != 0; n++) tick();
    check("drain_empty", expq.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 2'd0, 2048};
    vecs[1]  = '{16'h4000, 2'd0, 4095};
    vecs[2]  = '{16'h8000, 2'd0, 2048};
    vecs[3]  = '{16'hC000, 2'd0, 1};
    vecs[4]  = '{16'h2000, 2'd0, 3495};
    vecs[5]  = '{16'h6000, 2'd0, 3495};
    vecs[6]  = '{16'hA000, 2'd0, 601};
    vecs[7]  = '{16'h8000, 2'd2, 2048};
    vecs[8]  = '{16'hFFFF, 2'd2, 4095};
    vecs[9]  = '{16'h1234, 2'd2, 291};
    vecs[10] = '{16'h7FFF, 2'd3, 4095};
    vecs[11] = '{16'h8000, 2'd3, 0};
    vecs[12] = '{16'h0000, 2'd3, 4095};
    vecs[13] = '{16'h0000, 2'd1, 0};
    vecs[14] = '{16'h7FFF, 2'd1, 4095};
    vecs[15] = '{16'hFFFF, 2'd1, 0};
    vecs[16] = '{16'h4000, 2'd1, 2048};
    vecs[17] = '{16'hC000, 2'd1, 2047};
    vecs[18] = '{16'h0000, 2'd2, 0};
    vecs[19] = '{16'hE000, 2'd0, 601};
    ph4 = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    ex4 = '{2048, 4095, 2048, 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    phase     = '0;
    mode      = '0;
    cur_exp   = 0;

    // Reset state, and it holds until the first accepted input.
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_result", int'(result), 2048);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("idle_out_valid", out_valid, 0);
      check("idle_result", int'(result), 2048);
    end

    // Back-to-back sine quadrant points with exact latency.
    phase    = ph4[0];
    mode     = 2'd0;
    in_valid = 1'b1;
    for (int c = 1; c <= LAT + 3; c++) begin
      tick();
      if (c < 4) phase = ph4[c];
      else in_valid = 1'b0;
      if (c < LAT) check("lat_idle", out_valid, 0);
      else begin
        check("lat_valid", out_valid, 1);
        check("lat_result", int'(result), ex4[c - LAT]);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Directed vector table streamed with the scoreboard.
    sb_on = 1'b1;
    foreach (vecs[i]) send(vecs[i].ph, vecs[i].md, vecs[i].exp);
    drain();

    // Backpressure: three samples in flight, outputs frozen while out_ready is low.
    out_ready = 1'b0;
    send(16'h4000, 2'd0, 4095);
    send(16'h1234, 2'd2, 291);
    send(16'h8000, 2'd3, 0);
    phase    = 16'h4000;
    mode     = 2'd1;
    cur_exp  = 2048;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", out_valid, 1);
      check("stall_result", int'(result), 4095);
      check("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    send(16'h4000, 2'd1, 2048);
    drain();

    // Reset with two samples in flight: they must never appear.
    send(16'h4000, 2'd0, 4095);
    send(16'h8000, 2'd2, 2048);
    rst   = 1'b1;
    sb_on = 1'b0;
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_result", int'(result), 2048);
    rst = 1'b0;
    expq.delete();
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      check("midrst_flushed", out_valid, 0);
    end
    sb_on = 1'b1;
    send(16'hC000, 2'd0, 1);
    drain();
    sb_on = 1'b0;

    // Fractional sine phase: interpolated or nearest-lower depending on build.
    phase    = 16'h0020;
    mode     = 2'd0;
    in_valid = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      in_valid = 1'b0;
      if (c < LAT) check("frac_idle", out_valid, 0);
      else begin
        check("frac_valid", out_valid, 1);
        check("frac_result", int'(result), INTERP_EXP);
      end
    end
    tick();
    tick();

    // Random traffic with random backpressure against the model.
    sb_on = 1'b1;
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(3) != 0);
      in_valid  = ($urandom_range(3) != 0);
      phase     = 16'($urandom);
      mode      = 2'($urandom);
      cur_exp   = model(phase, mode);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    sb_on = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
